// File: rtl/riscv151_core.sv
// Single-cycle RV32I core with internal instruction and data memories and a
// tohost CSR. One instruction retires per clock; memories read combinationally.
module riscv151_core #(
  parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
  parameter logic [31:0] RESET_PC       = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FPGA_SERIAL_RX,
  output logic        FPGA_SERIAL_TX,
  output logic [31:0] csr
);

  localparam int unsigned MemWords = 16384;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [11:0] CsrTohost = 12'h51E;

  logic [31:0] pc_q, pc_d, csr_q, csr_d;
  logic [31:0] inst;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  logic        br_taken;

  logic [31:0] mem_addr, dmem_rdata, ld_word, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  st_be, dmem_be, imem_be;
  logic [31:0] st_data;
  logic        is_store, csr_hit;

  logic        rd_we;
  logic [31:0] rd_data;

  // Serial RX and clock frequency are unused; TX idles high.
  logic unused_serial;
  assign unused_serial  = ^{FPGA_SERIAL_RX, CPU_CLOCK_FREQ};
  assign FPGA_SERIAL_TX = 1'b1;
  assign csr            = csr_q;

  // Instruction field decode.
  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign funct3  = inst[14:12];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign imm_i   = {{20{inst[31]}}, inst[31:20]};
  assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u   = {inst[31:12], 12'b0};
  assign imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign csr_hit = (inst[31:20] == CsrTohost);

  // Shared adder for load, store and JALR targets.
  assign mem_addr = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
  assign is_store = rst && (opcode == OpStore);
  assign dmem_be  = (is_store && mem_addr[28]) ? st_be : 4'b0000;
  assign imem_be  = (is_store && mem_addr[29]) ? st_be : 4'b0000;

  // Only the 0x1 and 0x3 regions map dmem for loads.
  assign ld_word  = (mem_addr[31:30] == 2'b00 && mem_addr[28]) ? dmem_rdata : 32'd0;

  if (1'b1) begin : imem
    logic [31:0] mem [MemWords];
    // Byte-enabled synchronous write port.
    always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
        if (imem_be[i]) mem[mem_addr[15:2]][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
    assign inst = mem[pc_q[15:2]];
  end

  if (1'b1) begin : dmem
    logic [31:0] mem [MemWords];
    // Byte-enabled synchronous write port.
    always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_be[i]) mem[mem_addr[15:2]][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
    assign dmem_rdata = mem[mem_addr[15:2]];
  end

  // ALU shared by OP and OP-IMM; SUB only exists in the register form.
  always_comb begin
    alu_b   = (opcode == OpReg) ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    alu_res = 32'd0;
    case (funct3)
      3'b000: begin
        if (opcode == OpReg && inst[30]) alu_res = rs1_val - alu_b;
        else                             alu_res = rs1_val + alu_b;
      end
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: begin
        if (inst[30]) alu_res = $signed(rs1_val) >>> shamt;
        else          alu_res = rs1_val >> shamt;
      end
      3'b110: alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  // Branch condition.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Load lane extraction; misaligned accesses stay inside the aligned word.
  always_comb begin
    ld_byte = 8'h00;
    case (mem_addr[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  // Store lane enables with data replicated across lanes.
  always_comb begin
    st_be   = 4'b1111;
    st_data = rs2_val;
    case (funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << mem_addr[1:0];
        st_data = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_val[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = rs2_val;
      end
    endcase
  end

  // Next PC, writeback and CSR update; unsupported opcodes fall through as NOP.
  always_comb begin
    pc_d    = pc_q + 32'd4;
    csr_d   = csr_q;
    rd_we   = 1'b0;
    rd_data = alu_res;
    case (opcode)
      OpLui: begin
        rd_we   = 1'b1;
        rd_data = imm_u;
      end
      OpAuipc: begin
        rd_we   = 1'b1;
        rd_data = pc_q + imm_u;
      end
      OpJal: begin
        rd_we   = 1'b1;
        rd_data = pc_q + 32'd4;
        pc_d    = pc_q + imm_j;
      end
      OpJalr: begin
        rd_we   = 1'b1;
        rd_data = pc_q + 32'd4;
        pc_d    = {mem_addr[31:1], 1'b0};
      end
      OpBranch: begin
        if (br_taken) pc_d = pc_q + imm_b;
      end
      OpLoad: begin
        rd_we   = 1'b1;
        rd_data = ld_data;
      end
      OpImm, OpReg: begin
        rd_we = 1'b1;
      end
      OpSystem: begin
        // CSRRW (001) and CSRRWI (101) only.
        if (funct3[1:0] == 2'b01) begin
          rd_we   = 1'b1;
          rd_data = csr_hit ? csr_q : 32'd0;
          if (csr_hit) csr_d = funct3[2] ? {27'd0, rs1} : rs1_val;
        end
      end
      default: ;
    endcase
  end

  // Architectural state; register file is not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      csr_q <= 32'd0;
    end else begin
      pc_q  <= pc_d;
      csr_q <= csr_d;
    end
  end

  // Register file write port; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst && rd_we && rd != 5'd0) rf[rd] <= rd_data;
  end

endmodule

// File: tb/tb_riscv151_core.sv
// Testbench for riscv151_core: directed programs with fixed expectations plus
// random programs run in lockstep against an instruction-level model.
module tb_riscv151_core;

  localparam logic [31:0] ResetPc = 32'h1000_0000;
  localparam int          Words   = 16384;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        tx;
  logic [31:0] csr;

  riscv151_core dut (
    .clk           (clk),
    .rst           (rst),
    .FPGA_SERIAL_RX(rx),
    .FPGA_SERIAL_TX(tx),
    .csr           (csr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model state.
  logic [31:0] m_imem [Words];
  logic [31:0] m_dmem [Words];
  logic [31:0] m_x    [32];
  logic [31:0] m_pc, m_csr;

  logic [31:0] prog [$];
  logic [31:0] obs  [$];

  // Encoders.
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] r1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] r2, logic [4:0] r1,
                                        logic [2:0] f3);
    return {imm[11:5], r2, r1, f3, imm[4:0], OpStore};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] r2, logic [4:0] r1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], OpBranch};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
  endfunction
  function automatic logic [31:0] csr_w(logic [4:0] r1);
    return enc_i(12'h51E, r1, 3'b001, 5'd0, OpSystem);
  endfunction
  function automatic logic [31:0] csr_wi(logic [4:0] uimm);
    return enc_i(12'h51E, uimm, 3'b101, 5'd0, OpSystem);
  endfunction

  // Model memory helpers working byte by byte.
  function automatic logic [31:0] m_byte(logic [31:0] addr);
    logic [31:0] w;
    w = m_dmem[(addr >> 2) & 32'h3fff];
    return (w >> (8 * (addr & 32'd3))) & 32'hff;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] addr, int f3);
    logic [31:0] v, base;
    if ((addr >> 28) != 32'd1 && (addr >> 28) != 32'd3) return 32'd0;
    base = addr & ~32'd1;
    case (f3)
      0: begin v = m_byte(addr); if (v >= 32'h80) v = v | 32'hFFFF_FF00; end
      1: begin
        v = m_byte(base) | (m_byte(base + 1) << 8);
        if (v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      4: v = m_byte(addr);
      5: v = m_byte(base) | (m_byte(base + 1) << 8);
      default: v = m_dmem[(addr >> 2) & 32'h3fff];
    endcase
    return v;
  endfunction

  task automatic m_store(input logic [31:0] addr, input int f3, input logic [31:0] data);
    int          n;
    logic [31:0] base, a, bv, idx, sh;
    n    = 1 << f3;
    base = addr & ~32'(n - 1);
    for (int i = 0; i < n; i++) begin
      a   = base + 32'(i);
      bv  = (data >> (8 * i)) & 32'hff;
      idx = (a >> 2) & 32'h3fff;
      sh  = 8 * (a & 32'd3);
      if (((addr >> 28) & 32'd1) != 0) m_dmem[idx] = (m_dmem[idx] & ~(32'hff << sh)) | (bv << sh);
      if (((addr >> 29) & 32'd1) != 0) m_imem[idx] = (m_imem[idx] & ~(32'hff << sh)) | (bv << sh);
    end
  endtask

  function automatic logic [31:0] m_alu(int f3, bit alt, logic [31:0] a, logic [31:0] b);
    int sh;
    sh = int'(b & 32'd31);
    case (f3)
      0: return alt ? a - b : a + b;
      1: return a << sh;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: begin
        if (alt) return $signed(a) >>> sh;
        return a >> sh;
      end
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // One instruction of the reference machine.
  task automatic m_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, nxt, val;
    int          opc, rd, f3, r1, r2;
    bit          wr, tk;
    ins = m_imem[(m_pc >> 2) & 32'h3fff];
    opc = int'(ins & 32'h7f);
    rd  = int'((ins >> 7) & 32'h1f);
    f3  = int'((ins >> 12) & 32'h7);
    r1  = int'((ins >> 15) & 32'h1f);
    r2  = int'((ins >> 20) & 32'h1f);
    a   = m_x[r1];
    b   = m_x[r2];
    ii  = $signed(ins) >>> 20;
    is  = (ii & ~32'h1f) | ((ins >> 7) & 32'h1f);
    ib  = (ins[31] ? 32'hFFFF_F000 : 32'd0) | (32'(ins[7]) << 11)
        | (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
    iu  = ins & 32'hFFFF_F000;
    ij  = (ins[31] ? 32'hFFF0_0000 : 32'd0) | (ins & 32'h000F_F000)
        | (32'(ins[20]) << 11) | (((ins >> 21) & 32'h3ff) << 1);
    nxt = m_pc + 32'd4;
    wr  = 1'b0;
    val = 32'd0;
    case (7'(opc))
      OpLui:   begin wr = 1; val = iu; end
      OpAuipc: begin wr = 1; val = m_pc + iu; end
      OpJal:   begin wr = 1; val = m_pc + 4; nxt = m_pc + ij; end
      OpJalr:  begin wr = 1; val = m_pc + 4; nxt = (a + ii) & ~32'd1; end
      OpBranch: begin
        case (f3)
          0: tk = (a == b);
          1: tk = (a != b);
          4: tk = ($signed(a) < $signed(b));
          5: tk = ($signed(a) >= $signed(b));
          6: tk = (a < b);
          7: tk = (a >= b);
          default: tk = 0;
        endcase
        if (tk) nxt = m_pc + ib;
      end
      OpLoad:  begin wr = 1; val = m_load(a + ii, f3); end
      OpStore: m_store(a + is, f3, b);
      OpImm:   begin wr = 1; val = m_alu(f3, (f3 == 5) && ins[30], a, ii); end
      OpReg:   begin wr = 1; val = m_alu(f3, ins[30], a, b); end
      OpSystem: begin
        if (f3 == 1 || f3 == 5) begin
          wr  = 1;
          val = ((ins >> 20) == 32'h51E) ? m_csr : 32'd0;
          if ((ins >> 20) == 32'h51E) m_csr = (f3 == 5) ? 32'(r1) : a;
        end
      end
      default: ;
    endcase
    if (wr && rd != 0) m_x[rd] = val;
    m_pc = nxt;
  endtask

  // Copy prog into both memories (DUT and model); optionally clear data memory.
  task automatic load(input bit clr_dmem);
    for (int i = 0; i < Words; i++) begin
      dut.imem.mem[i] = 32'd0;
      m_imem[i]       = 32'd0;
      if (clr_dmem) begin
        dut.dmem.mem[i] = 32'd0;
        m_dmem[i]       = 32'd0;
      end
    end
    foreach (prog[i]) begin
      dut.imem.mem[i] = prog[i];
      m_imem[i]       = prog[i];
    end
  endtask

  // Assert reset while the previous program is running, then load the next one.
  task automatic reset_and_load(input bit clr_dmem);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_pc", dut.pc_q, ResetPc);
    check("rst_csr", csr, 32'd0);
    load(clr_dmem);
    repeat (2) @(posedge clk);
  endtask

  // Release reset and run in lockstep with the model for ncyc edges.
  task automatic run(input int ncyc);
    m_pc  = ResetPc;
    m_csr = 32'd0;
    for (int r = 0; r < 32; r++) m_x[r] = 32'd0;
    obs.delete();
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      m_step();
      check("step_pc", dut.pc_q, m_pc);
      check("step_csr", csr, m_csr);
      obs.push_back(csr);
    end
  endtask

  task automatic gen_random();
    logic [31:0] w;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    prog.delete();
    for (int r = 1; r <= 7; r++) begin
      prog.push_back(enc_u(20'($urandom()), 5'(r), OpLui));
      prog.push_back(enc_i(12'($urandom()), 5'(r), 3'b000, 5'(r), OpImm));
    end
    prog.push_back(enc_u(20'h10004, 5'd8, OpLui));
    prog.push_back(enc_u(20'h20004, 5'd9, OpLui));
    prog.push_back(enc_u(20'h30004, 5'd10, OpLui));
    for (int n = 0; n < 40; n++) begin
      rd = 5'($urandom_range(7, 0));
      r1 = 5'($urandom_range(10, 0));
      r2 = 5'($urandom_range(10, 0));
      f3 = 3'($urandom_range(7, 0));
      case ($urandom_range(11, 0))
        0, 1: begin
          prog.push_back(enc_r(((f3 == 0 || f3 == 5) && $urandom_range(1, 0) == 1) ? 7'h20 : 7'h00,
                               r2, r1, f3, rd, OpReg));
          if ($urandom_range(1, 0) == 1) prog.push_back(csr_w(rd));
        end
        2, 3: begin
          imm = 12'($urandom());
          if (f3 == 1) imm = 12'($urandom_range(31, 0));
          if (f3 == 5) imm = 12'($urandom_range(31, 0)) | ($urandom_range(1, 0) == 1 ? 12'h400 : 12'h0);
          prog.push_back(enc_i(imm, r1, f3, rd, OpImm));
          if ($urandom_range(1, 0) == 1) prog.push_back(csr_w(rd));
        end
        4: begin
          prog.push_back(enc_u(20'($urandom()), rd, ($urandom_range(1, 0) == 1) ? OpLui : OpAuipc));
          prog.push_back(csr_w(rd));
        end
        5: begin
          prog.push_back(enc_i(12'($urandom_range(63, 0)), 5'(8 + $urandom_range(2, 0)),
                               ld_f3[$urandom_range(4, 0)], rd, OpLoad));
          prog.push_back(csr_w(rd));
        end
        6: prog.push_back(enc_s(12'($urandom_range(63, 0)), r2, 5'(8 + $urandom_range(2, 0)),
                                3'($urandom_range(2, 0))));
        7: begin
          if ($urandom_range(1, 0) == 1)
            prog.push_back(enc_i(($urandom_range(3, 0) == 0) ? 12'h300 : 12'h51E, r1, 3'b001, rd,
                                 OpSystem));
          else
            prog.push_back(enc_i(($urandom_range(3, 0) == 0) ? 12'h300 : 12'h51E,
                                 5'($urandom_range(31, 0)), 3'b101, rd, OpSystem));
          prog.push_back(csr_w(rd));
        end
        8:  prog.push_back(enc_b(13'd8, r2, r1, br_f3[$urandom_range(5, 0)]));
        9:  begin prog.push_back(enc_j(21'd8, rd)); prog.push_back(csr_w(rd)); end
        10: begin
          prog.push_back(enc_u(20'd0, 5'd11, OpAuipc));
          prog.push_back(enc_i(12'd13, 5'd11, 3'b000, 5'd12, OpJalr));
          prog.push_back(enc_i(12'($urandom()), r1, 3'b000, rd, OpImm));
          prog.push_back(csr_w(5'd12));
        end
        default: begin
          case ($urandom_range(3, 0))
            0: w = 32'h0000_000F;
            1: w = 32'h0000_0073;
            2: w = 32'h0010_0073;
            default: begin w = $urandom(); w[6:0] = 7'h0b; end
          endcase
          prog.push_back(w);
        end
      endcase
    end
    prog.push_back(enc_j(21'd0, 5'd0));
    prog.push_back(enc_j(21'd0, 5'd0));
  endtask

  initial begin
    // Long reset with the first program already loaded.
    prog = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1, OpImm), enc_i(12'd7, 5'd0, 3'b000, 5'd2, OpImm),
             enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OpReg), csr_wi(5'd1), enc_j(21'd0, 5'd0)};
    load(1'b1);
    repeat (30) begin
      @(posedge clk);
      #1;
      check("hold_csr", csr, 32'd0);
    end
    check("hold_pc", dut.pc_q, ResetPc);
    check("tx_idle", {31'd0, tx}, 32'd1);
    run(8);
    check("pass_csr", obs[3], 32'h1);

    // Failure report.
    prog = '{enc_i(12'd7, 5'd0, 3'b000, 5'd1, OpImm), csr_w(5'd1), enc_j(21'd0, 5'd0)};
    reset_and_load(1'b1);
    run(6);
    check("fail_csr", obs[1], 32'h7);
    check("fail_testno", obs[1] >> 1, 32'd3);

    // Memory round trip.
    prog = '{enc_u(20'h10004, 5'd8, OpLui), enc_u(20'hDEADC, 5'd1, OpLui),
             enc_i(12'hEEF, 5'd1, 3'b000, 5'd1, OpImm), enc_s(12'd0, 5'd1, 5'd8, 3'b010),
             enc_i(12'h055, 5'd0, 3'b000, 5'd2, OpImm), enc_s(12'd1, 5'd2, 5'd8, 3'b000),
             enc_i(12'd0, 5'd8, 3'b010, 5'd3, OpLoad), csr_w(5'd3),
             enc_i(12'd3, 5'd8, 3'b000, 5'd4, OpLoad), csr_w(5'd4),
             enc_i(12'd2, 5'd8, 3'b101, 5'd5, OpLoad), csr_w(5'd5), enc_j(21'd0, 5'd0)};
    reset_and_load(1'b1);
    run(16);
    check("mem_lw", obs[7], 32'hDEAD_55EF);
    check("mem_lb", obs[9], 32'hFFFF_FFDE);
    check("mem_lhu", obs[11], 32'h0000_DEAD);

    // Reset while looping; data memory must survive.
    prog = '{enc_u(20'h10004, 5'd8, OpLui), enc_i(12'd0, 5'd8, 3'b010, 5'd3, OpLoad),
             csr_w(5'd3), enc_j(21'd0, 5'd0)};
    reset_and_load(1'b0);
    run(6);
    check("mem_retained", obs[2], 32'hDEAD_55EF);

    // Control flow.
    prog = '{enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OpImm), enc_i(12'd1, 5'd0, 3'b000, 5'd2, OpImm),
             enc_b(13'd8, 5'd2, 5'd1, 3'b100), csr_wi(5'd3),
             enc_b(13'd8, 5'd2, 5'd1, 3'b110), csr_wi(5'd5),
             enc_j(21'd8, 5'd5), csr_wi(5'd3), csr_w(5'd5),
             enc_u(20'd0, 5'd6, OpAuipc), enc_i(12'd13, 5'd6, 3'b000, 5'd7, OpJalr),
             csr_wi(5'd3), csr_w(5'd7),
             enc_i(12'd5, 5'd0, 3'b000, 5'd0, OpImm), csr_w(5'd0), enc_j(21'd0, 5'd0)};
    reset_and_load(1'b1);
    run(16);
    check("blt_bltu", obs[4], 32'd5);
    check("jal_link", obs[6], 32'h1000_001C);
    check("jalr_odd", obs[9], 32'h1000_002C);
    check("x0_zero", obs[11], 32'd0);

    // Random programs against the model.
    for (int t = 0; t < 10; t++) begin
      gen_random();
      reset_and_load(1'b1);
      run(prog.size() + 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
